// File: rtl/cpu_fch_s.sv
// ---------------------------------------------------------------------------
// cpu_fch_s : instruction fetch stage of the Selen core pipeline.
//
// Holds the program counter and fetches one word at a time from the level 1
// instruction cache. Only one request is outstanding at a time. Fetched words
// go to decode through the fetch/decode register, together with their PC and
// PC+4. When decode does not accept, one response waits in a skid buffer.
// Generated NOPs (flagged by nop_gen) fill the register on misses, stalls and
// flushes.
//
// Parameters
//   RESET_PC            first PC fetched after reset (bits [1:0] must be 0)
//   NOP_INST            instruction word handed to decode when nothing valid
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   fch_enb             fetch/decode register load enable (decode accepts)
//   fch_kill            flush; refetch from fch_pc_redirect
//   fch_pc_redirect     redirect target, bits [1:0] ignored
//   fch_il1_req         request to IL1, held until ack
//   fch_il1_addr        request word address
//   fch_il1_ack         one-cycle response strobe
//   fch_il1_rdata       instruction word, valid with ack
//   fch_stall           no instruction available for decode this cycle
//   fch_inst_out_reg    instruction to decode
//   fch_pc_out_reg      PC of fch_inst_out_reg
//   fch_pc_4_out_reg    PC+4 of fch_inst_out_reg
//   fch_nop_gen_out_reg output register holds a generated NOP
// ---------------------------------------------------------------------------
module cpu_fch_s #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fch_enb,
  input  logic        fch_kill,
  input  logic [31:0] fch_pc_redirect,
  output logic        fch_il1_req,
  output logic [31:0] fch_il1_addr,
  input  logic        fch_il1_ack,
  input  logic [31:0] fch_il1_rdata,
  output logic        fch_stall,
  output logic [31:0] fch_inst_out_reg,
  output logic [31:0] fch_pc_out_reg,
  output logic [31:0] fch_pc_4_out_reg,
  output logic        fch_nop_gen_out_reg
);

  // REQ : request outstanding at pc_q (or about to be issued)
  // HOLD: a response sits in the skid buffer waiting for decode
  // DROP: a killed request is still in flight; its data will be thrown away
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_out_q, pc4_out_d;
  logic        nop_q, nop_d;

  logic        avail;
  logic [31:0] avail_inst;
  logic [31:0] avail_pc;
  logic [31:0] redirect_pc;

  // Low address bits of the redirect target are forced to zero.
  assign redirect_pc = fch_pc_redirect & ~32'h0000_0003;

  // An instruction can be handed to decode either straight from the cache
  // response or from the skid buffer. A response arriving in DROP belongs to
  // a killed request and never counts.
  assign avail      = ((state_q == ST_REQ) && fch_il1_ack) || (state_q == ST_HOLD);
  assign avail_inst = (state_q == ST_HOLD) ? buf_inst_q : fch_il1_rdata;
  assign avail_pc   = (state_q == ST_HOLD) ? buf_pc_q   : pc_q;

  // In DROP pc_q still holds the address of the abandoned request, so the
  // address stays stable until its ack arrives.
  assign fch_il1_req  = !rst && ((state_q == ST_REQ) || (state_q == ST_DROP));
  assign fch_il1_addr = pc_q;
  assign fch_stall    = !avail;

  assign fch_inst_out_reg    = inst_q;
  assign fch_pc_out_reg      = pc_out_q;
  assign fch_pc_4_out_reg    = pc4_out_q;
  assign fch_nop_gen_out_reg = nop_q;

  // Next-state logic: kill overrides everything, otherwise the fetch state
  // machine advances and the output register loads when decode accepts.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    pc4_out_d  = pc4_out_q;
    nop_d      = nop_q;

    if (fch_kill) begin
      inst_d    = NOP_INST;
      pc_out_d  = 32'h0000_0000;
      pc4_out_d = 32'h0000_0000;
      nop_d     = 1'b1;
      case (state_q)
        ST_REQ: begin
          if (fch_il1_ack) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else begin
            target_d = redirect_pc;
            state_d  = ST_DROP;
          end
        end
        ST_HOLD: begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end
        ST_DROP: begin
          if (fch_il1_ack) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else begin
            target_d = redirect_pc;
          end
        end
        default: begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (fch_il1_ack) begin
            pc_d = pc_q + 32'd4;
            if (!fch_enb) begin
              buf_inst_d = fch_il1_rdata;
              buf_pc_d   = pc_q;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (fch_enb) begin
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (fch_il1_ack) begin
            pc_d    = target_q;
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase

      // With nothing available the PC fields keep their last values so
      // decode still sees a sensible PC alongside the bubble.
      if (fch_enb) begin
        if (avail) begin
          inst_d    = avail_inst;
          pc_out_d  = avail_pc;
          pc4_out_d = avail_pc + 32'd4;
          nop_d     = 1'b0;
        end else begin
          inst_d = NOP_INST;
          nop_d  = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      target_q   <= 32'h0000_0000;
      buf_inst_q <= 32'h0000_0000;
      buf_pc_q   <= 32'h0000_0000;
      inst_q     <= NOP_INST;
      pc_out_q   <= 32'h0000_0000;
      pc4_out_q  <= 32'h0000_0000;
      nop_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      pc4_out_q  <= pc4_out_d;
      nop_q      <= nop_d;
    end
  end

endmodule

// File: tb/tb_cpu_fch_s.sv
// ---------------------------------------------------------------------------
// tb_cpu_fch_s : directed self-checking bench for cpu_fch_s.
//
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wraparound.
// ---------------------------------------------------------------------------
module tb_cpu_fch_s;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        enb;
  logic        kill;
  logic [31:0] redirect;
  logic        ack;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] pcOut;
  logic [31:0] pc4Out;
  logic        nopGen;

  logic        enb2;
  logic        kill2;
  logic [31:0] redirect2;
  logic        ack2;
  logic [31:0] rdata2;
  logic        req2;
  logic [31:0] addr2;
  logic        stall2;
  logic [31:0] inst2;
  logic [31:0] pcOut2;
  logic [31:0] pc4Out2;
  logic        nopGen2;

  int errors;
  int checks;

  cpu_fch_s u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .fch_enb             (enb),
    .fch_kill            (kill),
    .fch_pc_redirect     (redirect),
    .fch_il1_req         (req),
    .fch_il1_addr        (addr),
    .fch_il1_ack         (ack),
    .fch_il1_rdata       (rdata),
    .fch_stall           (stall),
    .fch_inst_out_reg    (inst),
    .fch_pc_out_reg      (pcOut),
    .fch_pc_4_out_reg    (pc4Out),
    .fch_nop_gen_out_reg (nopGen)
  );

  cpu_fch_s #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk                 (clk),
    .rst                 (rst),
    .fch_enb             (enb2),
    .fch_kill            (kill2),
    .fch_pc_redirect     (redirect2),
    .fch_il1_req         (req2),
    .fch_il1_addr        (addr2),
    .fch_il1_ack         (ack2),
    .fch_il1_rdata       (rdata2),
    .fch_stall           (stall2),
    .fch_inst_out_reg    (inst2),
    .fch_pc_out_reg      (pcOut2),
    .fch_pc_4_out_reg    (pc4Out2),
    .fch_nop_gen_out_reg (nopGen2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put both instances into their reset state and release reset.
  task automatic doReset();
    rst  = 1'b1;
    enb  = 1'b0;
    kill = 1'b0;
    ack  = 1'b0;
    rdata = 32'h0;
    redirect = 32'h0;
    enb2 = 1'b0;
    ack2 = 1'b0;
    rdata2 = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Ack n consecutive requests from address 0 upward with enb=1.
  task automatic streamFromZero(input int n);
    enb = 1'b1;
    for (int i = 0; i < n; i++) begin
      ack   = 1'b1;
      rdata = 32'hA000_0000 + 32'(4 * i);
      tick();
    end
    ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    enb  = 1'b0;
    kill = 1'b0;
    ack  = 1'b0;
    rdata = 32'h0;
    redirect = 32'h0;
    enb2 = 1'b0;
    kill2 = 1'b0;
    redirect2 = 32'h0;
    ack2 = 1'b0;
    rdata2 = 32'h0;
    tick();
    tick();
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_low got=%b want=0", req);
    end
    checks++;
    if (inst !== NOP || pcOut !== 32'h0 || pc4Out !== 32'h0 || nopGen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs got inst=%h pc=%h pc4=%h nop=%b want inst=%h pc=0 pc4=0 nop=1",
               inst, pcOut, pc4Out, nopGen, NOP);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", req, addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    doReset();
    enb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expPc = 32'(4 * i);
      ack   = 1'b1;
      rdata = 32'hA000_0000 + expPc;
      #1;
      checks++;
      if (req !== 1'b1 || addr !== expPc || stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_req[%0d] got req=%b addr=%h stall=%b want req=1 addr=%h stall=0",
                 i, req, addr, stall, expPc);
      end
      tick();
      checks++;
      if (inst !== 32'hA000_0000 + expPc || pcOut !== expPc ||
          pc4Out !== expPc + 32'd4 || nopGen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_out[%0d] got inst=%h pc=%h pc4=%h nop=%b want inst=%h pc=%h pc4=%h nop=0",
                 i, inst, pcOut, pc4Out, nopGen, 32'hA000_0000 + expPc, expPc, expPc + 32'd4);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    doReset();
    enb = 1'b1;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || req !== 1'b1 || addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL delay_wait[%0d] got stall=%b req=%b addr=%h want stall=1 req=1 addr=0",
                 i, stall, req, addr);
      end
      tick();
      checks++;
      if (inst !== NOP || nopGen !== 1'b1 || pcOut !== 32'h0) begin
        errors++;
        $display("[TB] FAIL delay_out[%0d] got inst=%h nop=%b pc=%h want inst=%h nop=1 pc=0",
                 i, inst, nopGen, pcOut, NOP);
      end
    end
    ack   = 1'b1;
    rdata = 32'hA000_0000;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (inst !== 32'hA000_0000 || nopGen !== 1'b0 || pc4Out !== 32'h4 || addr !== 32'h4) begin
      errors++;
      $display("[TB] FAIL delay_late_ack got inst=%h nop=%b pc4=%h addr=%h want inst=a0000000 nop=0 pc4=4 addr=4",
               inst, nopGen, pc4Out, addr);
    end
  endtask

  task automatic test_hold();
    doReset();
    streamFromZero(4);
    enb   = 1'b0;
    ack   = 1'b1;
    rdata = 32'hB000_0010;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || stall !== 1'b0 || pcOut !== 32'hC || inst !== 32'hA000_000C) begin
      errors++;
      $display("[TB] FAIL hold_enter got req=%b stall=%b pc=%h inst=%h want req=0 stall=0 pc=c inst=a000000c",
               req, stall, pcOut, inst);
    end
    tick();
    checks++;
    if (req !== 1'b0 || pcOut !== 32'hC || nopGen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_frozen got req=%b pc=%h nop=%b want req=0 pc=c nop=0", req, pcOut, nopGen);
    end
    enb = 1'b1;
    tick();
    checks++;
    if (pcOut !== 32'h10 || pc4Out !== 32'h14 || inst !== 32'hB000_0010 || nopGen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release got pc=%h pc4=%h inst=%h nop=%b want pc=10 pc4=14 inst=b0000010 nop=0",
               pcOut, pc4Out, inst, nopGen);
    end
    checks++;
    if (req !== 1'b1 || addr !== 32'h14) begin
      errors++;
      $display("[TB] FAIL hold_next_req got req=%b addr=%h want req=1 addr=14", req, addr);
    end
    tick();
    checks++;
    if (inst !== NOP || nopGen !== 1'b1 || pcOut !== 32'h10 || pc4Out !== 32'h14) begin
      errors++;
      $display("[TB] FAIL bubble_keeps_pc got inst=%h nop=%b pc=%h pc4=%h want inst=%h nop=1 pc=10 pc4=14",
               inst, nopGen, pcOut, pc4Out, NOP);
    end
  endtask

  task automatic test_kill_drop();
    doReset();
    streamFromZero(8);
    kill     = 1'b1;
    redirect = 32'h80;
    tick();
    kill = 1'b0;
    #1;
    checks++;
    if (inst !== NOP || nopGen !== 1'b1 || pcOut !== 32'h0 || pc4Out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL drop_kill_out got inst=%h nop=%b pc=%h pc4=%h want inst=%h nop=1 pc=0 pc4=0",
               inst, nopGen, pcOut, pc4Out, NOP);
    end
    checks++;
    if (req !== 1'b1 || addr !== 32'h20) begin
      errors++;
      $display("[TB] FAIL drop_addr_held got req=%b addr=%h want req=1 addr=20", req, addr);
    end
    tick();
    ack   = 1'b1;
    rdata = 32'h0000_DEAD;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_stall got=%b want=1", stall);
    end
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (inst !== NOP || nopGen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_discard got inst=%h nop=%b want inst=%h nop=1", inst, nopGen, NOP);
    end
    checks++;
    if (req !== 1'b1 || addr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL drop_redirect got req=%b addr=%h want req=1 addr=80", req, addr);
    end
    ack   = 1'b1;
    rdata = 32'hC000_0080;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if (inst !== 32'hC000_0080 || pcOut !== 32'h80 || pc4Out !== 32'h84 || nopGen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_refetch got inst=%h pc=%h pc4=%h nop=%b want inst=c0000080 pc=80 pc4=84 nop=0",
               inst, pcOut, pc4Out, nopGen);
    end
  endtask

  task automatic test_kill_ack();
    doReset();
    streamFromZero(2);
    ack      = 1'b1;
    rdata    = 32'hA000_0008;
    kill     = 1'b1;
    redirect = 32'h40;
    tick();
    kill = 1'b0;
    ack  = 1'b0;
    #1;
    checks++;
    if (inst !== NOP || nopGen !== 1'b1 || pcOut !== 32'h0) begin
      errors++;
      $display("[TB] FAIL killack_out got inst=%h nop=%b pc=%h want inst=%h nop=1 pc=0",
               inst, nopGen, pcOut, NOP);
    end
    checks++;
    if (req !== 1'b1 || addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL killack_req got req=%b addr=%h want req=1 addr=40", req, addr);
    end
    // Park a response in the skid buffer, then kill from HOLD with an
    // unaligned target.
    enb   = 1'b0;
    ack   = 1'b1;
    rdata = 32'hA000_0040;
    tick();
    ack      = 1'b0;
    kill     = 1'b1;
    redirect = 32'h103;
    tick();
    kill = 1'b0;
    enb  = 1'b1;
    #1;
    checks++;
    if (req !== 1'b1 || addr !== 32'h100 || nopGen !== 1'b1 || inst !== NOP) begin
      errors++;
      $display("[TB] FAIL killhold got req=%b addr=%h nop=%b inst=%h want req=1 addr=100 nop=1 inst=%h",
               req, addr, nopGen, inst, NOP);
    end
    tick();
    checks++;
    if (inst !== NOP || nopGen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL killhold_buffer_dropped got inst=%h nop=%b want inst=%h nop=1", inst, nopGen, NOP);
    end
  endtask

  task automatic test_wrap();
    doReset();
    #1;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_first_req got req=%b addr=%h want req=1 addr=fffffffc", req2, addr2);
    end
    enb2   = 1'b1;
    ack2   = 1'b1;
    rdata2 = 32'h1234_5678;
    tick();
    ack2 = 1'b0;
    #1;
    checks++;
    if (pcOut2 !== 32'hFFFF_FFFC || pc4Out2 !== 32'h0 || inst2 !== 32'h1234_5678 || nopGen2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_out got pc=%h pc4=%h inst=%h nop=%b want pc=fffffffc pc4=0 inst=12345678 nop=0",
               pcOut2, pc4Out2, inst2, nopGen2);
    end
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_next_req got req=%b addr=%h want req=1 addr=0", req2, addr2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    #1;
    test_reset();
    test_stream();
    test_delayed_ack();
    test_hold();
    test_kill_drop();
    test_kill_ack();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
